// File: rtl/pid_multi_pkg.sv
// pid_multi_pkg: register offsets, FSM states and saturation helper shared by the multi-channel PID
package pid_multi_pkg;
  localparam logic [2:0] REG_SETPOINT = 3'd0;
  localparam logic [2:0] REG_KP       = 3'd1;
  localparam logic [2:0] REG_KI       = 3'd2;
  localparam logic [2:0] REG_KD       = 3'd3;
  localparam logic [2:0] REG_ILIM     = 3'd4;
  localparam logic [2:0] REG_OLIM     = 3'd5;
  localparam logic [2:0] REG_CTRL     = 3'd6;
  localparam logic [2:0] REG_RESULT   = 3'd7;

  typedef enum logic [2:0] {IDLE, LOAD, ERR, MUL_P, MUL_I, MUL_D, SUM, STORE} state_t;

  // Clamp to +/-lim, then to the int32 range (lim may exceed 2^31-1).
  function automatic logic signed [31:0] saturate(input logic signed [63:0] v, input logic [31:0] lim);
    logic signed [63:0] l, c;
    l = $signed({32'd0, lim});
    c = v > l ? l : v < -l ? -l : v;
    return c > 64'sh7FFF_FFFF ? 32'sh7FFF_FFFF :
           c < $signed(64'hFFFF_FFFF_8000_0000) ? $signed(32'h8000_0000) : $signed(c[31:0]);
  endfunction
endpackage

// File: rtl/pid_multi_if.sv
// pid_multi_if: Avalon-MM slave bus (address, write, writedata, read, readdata; read latency 1)
interface pid_multi_if #(parameter int ADDR_WIDTH = 5);
  logic [ADDR_WIDTH-1:0] avs_address;
  logic                  avs_write;
  logic [31:0]           avs_writedata;
  logic                  avs_read;
  logic [31:0]           avs_readdata;
  modport master (output avs_address, avs_write, avs_writedata, avs_read, input avs_readdata);
  modport slave  (input avs_address, avs_write, avs_writedata, avs_read, output avs_readdata);
endinterface

// File: rtl/pid_multi_datapath.sv
// pid_multi_datapath: one channel's ERR/MAC/SUM pass through a single shared multiplier
//   in: clk, rst_n, state, setpoint, position, kp/ki/kd, integral_limit, output_limit, integ_in, last_err_in
//   out: result, integ, err (valid at STORE)
module pid_multi_datapath
  import pid_multi_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int GAIN_WIDTH = 16,
  parameter int FRAC_BITS  = 8
)(
  input  logic                         clk,
  input  logic                         rst_n,
  input  state_t                       state,
  input  logic signed [DATA_WIDTH-1:0] setpoint,
  input  logic signed [DATA_WIDTH-1:0] position,
  input  logic signed [GAIN_WIDTH-1:0] kp,
  input  logic signed [GAIN_WIDTH-1:0] ki,
  input  logic signed [GAIN_WIDTH-1:0] kd,
  input  logic [31:0]                  integral_limit,
  input  logic [30:0]                  output_limit,
  input  logic signed [31:0]           integ_in,
  input  logic signed [DATA_WIDTH:0]   last_err_in,
  output logic signed [31:0]           result,
  output logic signed [31:0]           integ,
  output logic signed [DATA_WIDTH:0]   err
);
  logic signed [DATA_WIDTH-1:0]   pos_q;
  logic signed [DATA_WIDTH:0]     last_q, e;
  logic signed [DATA_WIDTH+1:0]   deriv;
  logic signed [63:0]             acc;
  logic signed [GAIN_WIDTH-1:0]   op_a;
  logic signed [32:0]             op_b;
  logic signed [GAIN_WIDTH+32:0]  prod;

  always_comb begin
    e    = (DATA_WIDTH+1)'(setpoint) - (DATA_WIDTH+1)'(pos_q);
    op_a = state == MUL_P ? kp : state == MUL_I ? ki : kd;
    op_b = state == MUL_P ? 33'(err) : state == MUL_I ? 33'(integ) : 33'(deriv);
    prod = (GAIN_WIDTH+33)'(op_a) * (GAIN_WIDTH+33)'(op_b);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pos_q  <= '0;
      last_q <= '0;
      err    <= '0;
      deriv  <= '0;
      integ  <= '0;
      acc    <= '0;
      result <= '0;
    end else
      case (state)
        LOAD: begin
          pos_q  <= position;
          integ  <= integ_in;
          last_q <= last_err_in;
        end
        ERR: begin
          err   <= e;
          integ <= saturate(64'(integ) + 64'(e), integral_limit);
          deriv <= (DATA_WIDTH+2)'(e) - (DATA_WIDTH+2)'(last_q);
        end
        MUL_P:        acc    <= 64'(prod);
        MUL_I, MUL_D: acc    <= acc + 64'(prod);
        SUM:          result <= saturate(acc >>> FRAC_BITS, {1'b0, output_limit});
        default: ;
      endcase
endmodule

// File: rtl/pid_controller_multi.sv
// pid_controller_multi: NUM_CHANNELS PID loops time-multiplexed over one datapath, Avalon-MM configured
//   in: clk_clk, reset_reset_n (async, active low), avs (slave bus), update_tick, position (ch0 in LSBs)
//   out: result (saturated per-channel outputs, ch0 in LSBs), busy, sweep_done
module pid_controller_multi
  import pid_multi_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int GAIN_WIDTH   = 16,
  parameter int FRAC_BITS    = 8,
  parameter int ADDR_WIDTH   = $clog2(NUM_CHANNELS) + 3
)(
  input  logic                               clk_clk,
  input  logic                               reset_reset_n,
  pid_multi_if.slave                         avs,
  input  logic                               update_tick,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] position,
  output logic [NUM_CHANNELS*32-1:0]         result,
  output logic                               busy,
  output logic                               sweep_done
);
  localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] sp;
    logic signed [GAIN_WIDTH-1:0] kp;
    logic signed [GAIN_WIDTH-1:0] ki;
    logic signed [GAIN_WIDTH-1:0] kd;
    logic [31:0]                  ilim;
    logic [30:0]                  olim;
    logic                         en;
  } cfg_t;

  // cfg is the host-visible copy; act is frozen at sweep start so mid-sweep writes wait a sweep.
  cfg_t                       cfg [NUM_CHANNELS];
  cfg_t                       act [NUM_CHANNELS];
  cfg_t                       sel, rc;
  logic signed [31:0]         integ [NUM_CHANNELS];
  logic signed [31:0]         res [NUM_CHANNELS];
  logic signed [DATA_WIDTH:0] last_err [NUM_CHANNELS];
  state_t                     state, state_n;
  logic [CW-1:0]              ch, a_idx;
  logic                       pending, clr_cur, last, a_ok, wr_en, clr_wr;
  logic [ADDR_WIDTH-1:0]      addr;
  logic [2:0]                 a_reg;
  logic [31:0]                a_ch, rd;
  logic signed [31:0]         dp_result, dp_integ;
  logic signed [DATA_WIDTH:0] dp_err;

  assign addr   = avs.avs_address;
  assign a_reg  = addr[2:0];
  assign a_ch   = 32'(addr) >> 3;
  assign a_ok   = a_ch < NUM_CHANNELS;
  assign a_idx  = CW'(a_ch);
  assign wr_en  = avs.avs_write && a_ok;
  assign clr_wr = wr_en && a_reg == REG_CTRL && avs.avs_writedata[1];
  assign sel    = act[ch];
  assign last   = ch == CW'(NUM_CHANNELS - 1);
  assign busy   = state != IDLE;
  assign sweep_done = state == STORE && last;

  for (genvar i = 0; i < NUM_CHANNELS; i++) assign result[i*32 +: 32] = res[i];

  always_comb begin
    state_n = state == IDLE  ? (update_tick || pending ? LOAD : IDLE) :
              state == STORE ? (last ? IDLE : LOAD) : state_t'(state + 3'd1);
    rc = cfg[a_idx];
    rd = !a_ok                 ? '0 :
         a_reg == REG_SETPOINT ? 32'(rc.sp) :
         a_reg == REG_KP       ? 32'(rc.kp) :
         a_reg == REG_KI       ? 32'(rc.ki) :
         a_reg == REG_KD       ? 32'(rc.kd) :
         a_reg == REG_ILIM     ? rc.ilim :
         a_reg == REG_OLIM     ? {1'b0, rc.olim} :
         a_reg == REG_CTRL     ? {31'd0, rc.en} : res[a_idx];
  end

  pid_multi_datapath #(
    .DATA_WIDTH(DATA_WIDTH),
    .GAIN_WIDTH(GAIN_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_dp (
    .clk           (clk_clk),
    .rst_n         (reset_reset_n),
    .state         (state),
    .setpoint      (sel.sp),
    .position      (position[int'(ch)*DATA_WIDTH +: DATA_WIDTH]),
    .kp            (sel.kp),
    .ki            (sel.ki),
    .kd            (sel.kd),
    .integral_limit(sel.ilim),
    .output_limit  (sel.olim),
    .integ_in      (integ[ch]),
    .last_err_in   (last_err[ch]),
    .result        (dp_result),
    .integ         (dp_integ),
    .err           (dp_err)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      state            <= IDLE;
      ch               <= '0;
      pending          <= 1'b0;
      clr_cur          <= 1'b0;
      avs.avs_readdata <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        cfg[i]      <= '0;
        act[i]      <= '0;
        integ[i]    <= '0;
        res[i]      <= '0;
        last_err[i] <= '0;
      end
    end else begin
      state   <= state_n;
      pending <= state == IDLE ? 1'b0 : pending || update_tick;
      ch      <= state != STORE ? ch : last ? '0 : ch + 1'b1;
      // A clear aimed at the channel in flight must also suppress that pass's integrator store.
      clr_cur <= clr_wr && a_idx == ch && busy ? 1'b1 : state == LOAD ? 1'b0 : clr_cur;
      if (avs.avs_read) avs.avs_readdata <= rd;
      if (state == IDLE && state_n == LOAD) act <= cfg;
      if (wr_en)
        case (a_reg)
          REG_SETPOINT: cfg[a_idx].sp   <= avs.avs_writedata[DATA_WIDTH-1:0];
          REG_KP:       cfg[a_idx].kp   <= avs.avs_writedata[GAIN_WIDTH-1:0];
          REG_KI:       cfg[a_idx].ki   <= avs.avs_writedata[GAIN_WIDTH-1:0];
          REG_KD:       cfg[a_idx].kd   <= avs.avs_writedata[GAIN_WIDTH-1:0];
          REG_ILIM:     cfg[a_idx].ilim <= avs.avs_writedata;
          REG_OLIM:     cfg[a_idx].olim <= avs.avs_writedata[30:0];
          REG_CTRL:     cfg[a_idx].en   <= avs.avs_writedata[0];
          default: ;
        endcase
      if (state == STORE) begin
        res[ch]      <= sel.en ? dp_result : '0;
        integ[ch]    <= sel.en && !clr_cur ? dp_integ : '0;
        last_err[ch] <= sel.en ? dp_err : '0;
      end
      if (clr_wr) integ[a_idx] <= '0;
    end
endmodule

// File: tb/tb_pid_controller_multi.sv
// tb_pid_controller_multi: directed self-checking bench for pid_controller_multi (4 channels)
module tb_pid_controller_multi;
  import pid_multi_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         update_tick = 1'b0;
  logic [63:0]  position = '0;
  logic [127:0] result;
  logic         busy, sweep_done;
  int           errors = 0;
  int           checks = 0;

  pid_multi_if #(.ADDR_WIDTH(5)) avs();

  pid_controller_multi #(.NUM_CHANNELS(4)) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .avs          (avs),
    .update_tick  (update_tick),
    .position     (position),
    .result       (result),
    .busy         (busy),
    .sweep_done   (sweep_done)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ad(input int c, input logic [2:0] r);
    return {2'(c), r};
  endfunction

  function automatic logic signed [31:0] res_of(input int c);
    return result[c*32 +: 32];
  endfunction

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    avs.avs_address = a;
    avs.avs_writedata = d;
    avs.avs_write = 1'b1;
    @(negedge clk);
    avs.avs_write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    avs.avs_address = a;
    avs.avs_read = 1'b1;
    @(negedge clk);
    avs.avs_read = 1'b0;
    d = avs.avs_readdata;
  endtask

  task automatic tick();
    update_tick = 1'b1;
    @(negedge clk);
    update_tick = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", tag, busy, n);
    end
  endtask

  task automatic run_sweep(input string tag);
    tick();
    wait_idle(tag);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h, required 0", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL reset_sweep_done: got %b, required 0", sweep_done); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d, required %0d", dut.state, IDLE); end
    rst_n = 1'b1;
    update_tick = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_no_pending: busy=%b, required 0", busy); end
  endtask

  task automatic test_sweep_timing();
    int cnt = 0, sd = 0;
    logic seen = 1'b0;
    tick();
    for (int n = 0; n < 100 && busy; n++) begin
      cnt++;
      if (sweep_done) sd = cnt;
      @(negedge clk);
    end
    checks++; if (cnt != 28) begin errors++; $display("FAIL busy_cycles: got %0d, required 28", cnt); end
    checks++; if (sd != 28) begin errors++; $display("FAIL sweep_done_cycle: got %0d, required 28", sd); end
    repeat (5) begin
      seen |= busy;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL no_extra_sweep: busy seen=%b, required 0", seen); end
  endtask

  task automatic test_proportional();
    logic [31:0] d;
    logic signed [31:0] exp;
    position[15:0]  = 16'd40;
    position[31:16] = 16'd40;
    position[63:48] = 16'd7;
    wr(ad(0, REG_SETPOINT), 32'd100);
    wr(ad(0, REG_KP), 32'd256);
    wr(ad(0, REG_OLIM), 32'd1000);
    wr(ad(0, REG_CTRL), 32'd1);
    run_sweep("prop");
    for (int c = 0; c < 4; c++) begin
      exp = c == 0 ? 32'sd60 : 32'sd0;
      checks++;
      if (res_of(c) !== exp) begin errors++; $display("FAIL prop_result%0d: got %0d, required %0d", c, res_of(c), exp); end
    end
    rd(ad(0, REG_RESULT), d);
    checks++; if (d !== 32'd60) begin errors++; $display("FAIL read_result: got %0d, required 60", d); end
    wr(ad(0, REG_RESULT), 32'd123);
    rd(ad(0, REG_RESULT), d);
    checks++; if (d !== 32'd60) begin errors++; $display("FAIL result_write_ignored: got %0d, required 60", d); end
    rd(ad(0, REG_SETPOINT), d);
    checks++; if (d !== 32'd100) begin errors++; $display("FAIL read_setpoint: got %0d, required 100", d); end
  endtask

  task automatic test_integral();
    int exp [4] = '{60, 120, 150, 150};
    wr(ad(1, REG_SETPOINT), 32'd100);
    wr(ad(1, REG_KI), 32'd256);
    wr(ad(1, REG_ILIM), 32'd150);
    wr(ad(1, REG_OLIM), 32'd1000);
    wr(ad(1, REG_CTRL), 32'd1);
    for (int k = 0; k < 4; k++) begin
      run_sweep("integ");
      checks++;
      if (res_of(1) !== exp[k]) begin errors++; $display("FAIL integ_sweep%0d: got %0d, required %0d", k, res_of(1), exp[k]); end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] d;
    position[47:32] = 16'd0;
    wr(ad(2, REG_SETPOINT), 32'd1000);
    wr(ad(2, REG_KP), 32'h7FFF);
    wr(ad(2, REG_OLIM), 32'd5000);
    wr(ad(2, REG_CTRL), 32'd1);
    run_sweep("sat_pos");
    checks++; if (res_of(2) !== 5000) begin errors++; $display("FAIL sat_pos: got %0d, required 5000", res_of(2)); end
    wr(ad(2, REG_SETPOINT), 32'hFFFF_FC18);
    rd(ad(2, REG_SETPOINT), d);
    checks++; if (d !== 32'hFFFF_FC18) begin errors++; $display("FAIL setpoint_sign_ext: got %h, required FFFFFC18", d); end
    run_sweep("sat_neg");
    checks++; if (res_of(2) !== -5000) begin errors++; $display("FAIL sat_neg: got %0d, required -5000", res_of(2)); end
  endtask

  task automatic test_back_to_back();
    logic seen = 1'b0;
    tick();
    repeat (3) @(negedge clk);
    wr(ad(0, REG_KP), 32'd512);
    tick();
    tick();
    for (int n = 0; n < 100 && !sweep_done; n++) @(negedge clk);
    checks++; if (sweep_done !== 1'b1) begin errors++; $display("FAIL b2b_sweep_done: got %b, required 1", sweep_done); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: busy=%b, required 0", busy); end
    checks++; if (res_of(0) !== 60) begin errors++; $display("FAIL b2b_old_kp: got %0d, required 60", res_of(0)); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_pending_start: busy=%b, required 1", busy); end
    wait_idle("b2b");
    checks++; if (res_of(0) !== 120) begin errors++; $display("FAIL b2b_new_kp: got %0d, required 120", res_of(0)); end
    repeat (10) begin
      seen |= busy;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL b2b_one_deep: busy seen=%b, required 0", seen); end
  endtask

  task automatic test_tick_at_store();
    tick();
    for (int n = 0; n < 100 && !sweep_done; n++) @(negedge clk);
    update_tick = 1'b1;
    @(negedge clk);
    update_tick = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL store_tick_idle: busy=%b, required 0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL store_tick_kept: busy=%b, required 1", busy); end
    wait_idle("store_tick");
  endtask

  task automatic test_clear_integral();
    logic [31:0] d;
    tick();
    repeat (8) @(negedge clk);
    wr(ad(1, REG_CTRL), 32'd3);
    checks++; if (dut.integ[1] !== 0) begin errors++; $display("FAIL clear_immediate: integ=%0d, required 0", dut.integ[1]); end
    wait_idle("clear");
    checks++; if (dut.integ[1] !== 0) begin errors++; $display("FAIL clear_store: integ=%0d, required 0", dut.integ[1]); end
    checks++; if (res_of(1) !== 150) begin errors++; $display("FAIL clear_pass_result: got %0d, required 150", res_of(1)); end
    rd(ad(1, REG_CTRL), d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL ctrl_readback: got %0d, required 1", d); end
    run_sweep("after_clear");
    checks++; if (res_of(1) !== 60) begin errors++; $display("FAIL after_clear: got %0d, required 60", res_of(1)); end
  endtask

  initial begin
    avs.avs_address = '0;
    avs.avs_write = 1'b0;
    avs.avs_writedata = '0;
    avs.avs_read = 1'b0;
    update_tick = 1'b1;
    test_reset();
    test_sweep_timing();
    test_proportional();
    test_integral();
    test_saturation();
    test_back_to_back();
    test_tick_at_store();
    test_clear_integral();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
